// File: rtl/frank6000_cpu_pkg.sv
// Shared constants for the frank6000 accumulator CPU: opcodes, field widths and storage sizes.
package frank6000_cpu_pkg;

   localparam int unsigned INSTR_W     = 16;
   localparam int unsigned OPC_W       = 4;
   localparam int unsigned REG_W       = 4;
   localparam int unsigned K_W         = 8;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned BIT_W       = 3;
   localparam int unsigned MEM_DEPTH   = 256;
   localparam int unsigned NUM_REGS    = 16;
   localparam int unsigned STACK_DEPTH = 8;
   localparam int unsigned PC_W        = $clog2(MEM_DEPTH);
   localparam int unsigned SP_W        = $clog2(STACK_DEPTH);

   localparam logic [OPC_W-1:0] OP_NOP    = 4'h0;
   localparam logic [OPC_W-1:0] OP_MOVLW  = 4'h1;
   localparam logic [OPC_W-1:0] OP_MOVWF  = 4'h2;
   localparam logic [OPC_W-1:0] OP_MOVFW  = 4'h3;
   localparam logic [OPC_W-1:0] OP_ADDWF  = 4'h4;
   localparam logic [OPC_W-1:0] OP_ADDLW  = 4'h5;
   localparam logic [OPC_W-1:0] OP_CLRW   = 4'h6;
   localparam logic [OPC_W-1:0] OP_CLRF   = 4'h7;
   localparam logic [OPC_W-1:0] OP_INCF   = 4'h8;
   localparam logic [OPC_W-1:0] OP_DECFSZ = 4'h9;
   localparam logic [OPC_W-1:0] OP_GOTO   = 4'hA;
   localparam logic [OPC_W-1:0] OP_CALL   = 4'hB;
   localparam logic [OPC_W-1:0] OP_RETURN = 4'hC;
   localparam logic [OPC_W-1:0] OP_BTFSS  = 4'hD;
   localparam logic [OPC_W-1:0] OP_RRF    = 4'hE;
   localparam logic [OPC_W-1:0] OP_RSV    = 4'hF;

endpackage

// File: rtl/frank6000_cpu_instr_memory.sv
// Program store: synchronous write port, asynchronous read port. The array is named mem so a
// host can preload it hierarchically.
module instr_memory
   import frank6000_cpu_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_we,
   input  logic [PC_W-1:0]    i_waddr,
   input  logic [INSTR_W-1:0] i_wdata,
   input  logic [PC_W-1:0]    i_raddr,
   output logic [INSTR_W-1:0] o_rdata
);

   logic [INSTR_W-1:0] mem [0:MEM_DEPTH-1];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/frank6000_cpu.sv
// Single-cycle 8-bit accumulator CPU: W, 16-entry register file, 8-entry call stack and a
// sticky detector for a program parked on GOTO to itself.
module frank6000_cpu
   import frank6000_cpu_pkg::*;
(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [PC_W-1:0]    i_instr_addr,
   input  logic [INSTR_W-1:0] i_instr,
   input  logic               i_we,
   input  logic               i_ON,
   output logic [DATA_W-1:0]  o_WREG,
   output logic               o_loopf
);

   logic [PC_W-1:0]   r_pc;
   logic [DATA_W-1:0] r_w;
   logic [DATA_W-1:0] r_regs  [NUM_REGS];
   logic [PC_W-1:0]   r_stack [STACK_DEPTH];
   logic [SP_W-1:0]   r_sp;
   logic              r_loopf;

   logic [INSTR_W-1:0] w_instr;
   logic [OPC_W-1:0]   w_op;
   logic [REG_W-1:0]   w_r;
   logic [K_W-1:0]     w_k;
   logic               w_d;
   logic [BIT_W-1:0]   w_b;
   logic [DATA_W-1:0]  w_reg_val;
   logic [DATA_W-1:0]  w_sum;
   logic [DATA_W-1:0]  w_dec;
   logic               w_skip;
   logic [PC_W-1:0]    w_pc_next;

   instr_memory Instruction_Memory (
      .i_clk   (i_clk),
      .i_we    (i_we),
      .i_waddr (i_instr_addr),
      .i_wdata (i_instr),
      .i_raddr (r_pc),
      .o_rdata (w_instr)
   );

   assign w_op      = w_instr[15:12];
   assign w_r       = w_instr[11:8];
   assign w_k       = w_instr[7:0];
   assign w_d       = w_instr[0];
   assign w_b       = w_instr[2:0];
   assign w_reg_val = r_regs[w_r];
   assign w_sum     = r_w + w_reg_val;
   assign w_dec     = w_reg_val - 8'd1;

   always_comb begin
      w_skip    = 1'b0;
      w_pc_next = r_pc + 8'd1;
      case (w_op)
         OP_DECFSZ: w_skip = (w_dec == '0);
         OP_BTFSS:  w_skip = w_reg_val[w_b];
         OP_GOTO:   w_pc_next = w_k;
         OP_CALL:   w_pc_next = w_k;
         OP_RETURN: w_pc_next = r_stack[r_sp - 3'd1];
         default:   ;
      endcase
      // 8-bit add wraps naturally, so 254 + 2 lands on 0
      if (w_skip) begin
         w_pc_next = r_pc + 8'd2;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_pc    <= '0;
         r_w     <= '0;
         r_sp    <= '0;
         r_loopf <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (i_ON) begin
         r_pc <= w_pc_next;
         case (w_op)
            OP_MOVLW:  r_w <= w_k;
            OP_MOVWF:  r_regs[w_r] <= r_w;
            OP_MOVFW:  r_w <= w_reg_val;
            OP_ADDWF: begin
               if (w_d) r_regs[w_r] <= w_sum;
               else     r_w <= w_sum;
            end
            OP_ADDLW:  r_w <= r_w + w_k;
            OP_CLRW:   r_w <= '0;
            OP_CLRF:   r_regs[w_r] <= '0;
            OP_INCF:   r_regs[w_r] <= w_reg_val + 8'd1;
            OP_DECFSZ: r_regs[w_r] <= w_dec;
            OP_CALL: begin
               r_stack[r_sp] <= r_pc + 8'd1;
               r_sp          <= r_sp + 3'd1;
            end
            OP_RETURN: r_sp <= r_sp - 3'd1;
            OP_RRF:    r_regs[w_r] <= {1'b0, w_reg_val[7:1]};
            OP_NOP, OP_RSV: ;
            default:   ;
         endcase
         if (w_op == OP_GOTO && w_k == r_pc) begin
            r_loopf <= 1'b1;
         end
      end
   end

   assign o_WREG  = r_w;
   assign o_loopf = r_loopf;

endmodule

// File: tb/tb_frank6000_cpu.sv
// Directed bench for frank6000_cpu: per-edge expected W/loop-flag pairs are queued as each
// program is started and popped after every executing edge.
module tb_frank6000_cpu;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b0;
   logic [7:0]  i_instr_addr = '0;
   logic [15:0] i_instr = '0;
   logic        i_we = 1'b0;
   logic        i_ON = 1'b0;
   logic [7:0]  o_WREG;
   logic        o_loopf;

   typedef struct {
      string      tag;
      logic [7:0] w;
      logic       lf;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   frank6000_cpu dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_instr_addr (i_instr_addr),
      .i_instr      (i_instr),
      .i_we         (i_we),
      .i_ON         (i_ON),
      .o_WREG       (o_WREG),
      .o_loopf      (o_loopf)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic push(input string tag, input logic [7:0] w, input logic lf);
      exp_t e;
      e.tag = tag;
      e.w   = w;
      e.lf  = lf;
      sb.push_back(e);
   endtask

   // ws holds n bytes, first executing edge in the most significant used byte;
   // loopf is expected high from edge lf_at onward (1-based)
   task automatic exp_seq(input string tag, input int n, input logic [127:0] ws, input int lf_at);
      for (int i = 0; i < n; i++) begin
         push($sformatf("%s_e%0d", tag, i + 1), ws[8*(n-1-i) +: 8], (i + 1) >= lf_at);
      end
   endtask

   task automatic run(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         tick();
         if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $error("FAIL scoreboard_empty: observed no entry expected one");
         end else begin
            e = sb.pop_front();
            chk8({e.tag, "_w"}, o_WREG, e.w);
            chk8({e.tag, "_lf"}, {7'd0, o_loopf}, {7'd0, e.lf});
         end
      end
   endtask

   task automatic load(input logic [7:0] addr, input logic [15:0] word);
      i_we         = 1'b1;
      i_instr_addr = addr;
      i_instr      = word;
      tick();
      i_we = 1'b0;
   endtask

   task automatic start(input string tag);
      i_ON  = 1'b0;
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      chk8({tag, "_rst_w"}, o_WREG, 8'h00);
      chk8({tag, "_rst_lf"}, {7'd0, o_loopf}, 8'h00);
      chk8({tag, "_rst_pc"}, dut.r_pc, 8'h00);
      i_ON = 1'b1;
   endtask

   task automatic load_loop_prog();
      i_ON = 1'b0;
      load(8'h00, 16'h1003);
      load(8'h01, 16'h2100);
      load(8'h02, 16'h6000);
      load(8'h03, 16'h5002);
      load(8'h04, 16'h9100);
      load(8'h05, 16'hA003);
      load(8'h06, 16'hA006);
   endtask

   initial begin
      // Move/add
      load(8'h00, 16'h1005);
      load(8'h01, 16'h5003);
      load(8'h02, 16'hA002);
      start("mv");
      exp_seq("mv", 4, 128'h05_08_08_08, 3);
      run(4);

      // Clear/register
      i_ON = 1'b0;
      load(8'h00, 16'h10AA);
      load(8'h01, 16'h2300);
      load(8'h02, 16'h6000);
      load(8'h03, 16'h3300);
      load(8'h04, 16'h7300);
      load(8'h05, 16'h3300);
      load(8'h06, 16'hA006);
      start("clr");
      exp_seq("clr", 7, 128'hAA_AA_00_AA_AA_00_00, 7);
      run(7);

      // Loop with DECFSZ skip
      load_loop_prog();
      start("lp");
      exp_seq("lp", 12, 128'h03_03_00_02_02_02_04_04_04_06_06_06, 12);
      run(11);
      chk8("lp_skip_pc", dut.r_pc, 8'h06);
      run(1);
      chk8("lp_r1", dut.r_regs[1], 8'h00);

      // Collatz step, odd path
      i_ON = 1'b0;
      load(8'h00, 16'h1007);
      load(8'h01, 16'h2200);
      load(8'h02, 16'hD200);
      load(8'h03, 16'hA009);
      load(8'h04, 16'h3200);
      load(8'h05, 16'h4201);
      load(8'h06, 16'h4201);
      load(8'h07, 16'h8200);
      load(8'h08, 16'hA00A);
      load(8'h09, 16'hE200);
      load(8'h0A, 16'h3200);
      load(8'h0B, 16'hA00B);
      start("codd");
      exp_seq("codd", 10, 128'h07_07_07_07_07_07_07_07_16_16, 10);
      run(10);
      chk8("codd_r2", dut.r_regs[2], 8'h16);

      // Collatz step, even path
      i_ON = 1'b0;
      load(8'h00, 16'h1016);
      start("cev");
      exp_seq("cev", 7, 128'h16_16_16_16_16_0B_0B, 7);
      run(7);
      chk8("cev_r2", dut.r_regs[2], 8'h0B);

      // INCF wrap 255 -> 0
      i_ON = 1'b0;
      load(8'h00, 16'h10FF);
      load(8'h01, 16'h2200);
      load(8'h02, 16'h8200);
      load(8'h03, 16'h3200);
      load(8'h04, 16'hA004);
      start("inc");
      exp_seq("inc", 5, 128'hFF_FF_FF_00_00, 5);
      run(5);

      // Three-deep CALL/RETURN
      i_ON = 1'b0;
      load(8'h00, 16'hB010);
      load(8'h01, 16'h5001);
      load(8'h02, 16'hA002);
      load(8'h10, 16'h5010);
      load(8'h11, 16'hB020);
      load(8'h12, 16'h5002);
      load(8'h13, 16'hC000);
      load(8'h20, 16'h5020);
      load(8'h21, 16'hB030);
      load(8'h22, 16'h5004);
      load(8'h23, 16'hC000);
      load(8'h30, 16'h5040);
      load(8'h31, 16'hC000);
      start("call");
      exp_seq("call", 13, 128'h00_10_10_30_30_70_70_74_74_76_76_77_77, 13);
      run(13);

      // Nine-deep nest: the 9th push overwrites entry 0, so the first RETURN lands at 0x51
      i_ON = 1'b0;
      load(8'h00, 16'hA040);
      for (int i = 0; i < 9; i++) begin
         load(8'(8'h40 + 2 * i), 16'hB000 | 16'(8'h42 + 2 * i));
      end
      load(8'h52, 16'hC000);
      load(8'h51, 16'hA051);
      start("deep");
      exp_seq("deep", 12, 128'h0, 12);
      run(11);
      chk8("deep_ret_pc", dut.r_pc, 8'h51);
      run(1);

      // Run enable freeze mid-program
      load_loop_prog();
      start("on");
      exp_seq("on", 5, 128'h03_03_00_02_02, 99);
      run(5);
      i_ON = 1'b0;
      for (int i = 0; i < 5; i++) begin
         push($sformatf("off_c%0d", i), 8'h02, 1'b0);
         run(1);
         chk8($sformatf("off_pc_c%0d", i), dut.r_pc, 8'h05);
      end
      i_ON = 1'b1;
      exp_seq("resume", 7, 128'h02_04_04_04_06_06_06, 7);
      run(7);

      // Reset mid-run with run enable high
      i_rst = 1'b1;
      push("midrst", 8'h00, 1'b0);
      run(1);
      chk8("midrst_pc", dut.r_pc, 8'h00);
      i_rst = 1'b0;

      // Write while halted, then execute; same-edge write to PC executes the old word
      i_ON = 1'b0;
      load(8'h00, 16'h1077);
      load(8'h01, 16'hA001);
      i_ON         = 1'b1;
      i_we         = 1'b1;
      i_instr_addr = 8'h00;
      i_instr      = 16'h1011;
      push("wr_old", 8'h77, 1'b0);
      run(1);
      i_we = 1'b0;
      push("wr_loop", 8'h77, 1'b1);
      run(1);
      start("wr_new");
      push("wr_new", 8'h11, 1'b0);
      run(1);

      chk8("sb_drained", 8'(sb.size()), 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
